ct_spsram_1024x64_ctrl: RTL and testbench
=========================================

# ct_spsram_1024x64_ctrl

Access controller for the 1024x64 single-port IFU SRAM. After reset it clears every entry to zero, then shares the one SRAM port between a read requester (lookup) and a write requester (refill) with round-robin arbitration. It drives the SRAM's active-low CEN/GWEN/WEN pins directly and returns read data with a valid strobe one cycle after grant.

## Interface
- ADDR_WIDTH, 10, SRAM address width (depth 1<<ADDR_WIDTH)
- DATA_WIDTH, 64, SRAM data width; bit-granular write mask
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- rd_req  in  1  read request, level
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read accepted this cycle (combinational from req/state)
- rd_vld  out  1  read data valid (registered)
- rd_data  out  DATA_WIDTH  read data, meaningful only when rd_vld
- wr_req  in  1  write request, level
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_bmask  in  DATA_WIDTH  per-bit write enable, active-high
- wr_gnt  out  1  write accepted this cycle
- init_busy  out  1  clear sweep in progress
- sram_A  out  ADDR_WIDTH  to SRAM A
- sram_CEN  out  1  to SRAM CEN, active-low
- sram_GWEN  out  1  to SRAM GWEN, active-low
- sram_WEN  out  DATA_WIDTH  to SRAM WEN, active-low per bit
- sram_D  out  DATA_WIDTH  to SRAM D
- sram_Q  in  DATA_WIDTH  from SRAM Q, valid one cycle after a read access

## Operation
- States: INIT, RUN. RST=1 forces INIT with init counter 0, rr pointer = read, rd_vld 0.
- INIT: each cycle writes address = counter: CEN=0, GWEN=0, WEN=all 0, D=0. Counter increments; after writing address 1023 next state RUN. rd_gnt=wr_gnt=0 in INIT regardless of requests. init_busy=1 in INIT.
- RUN: one requester: granted immediately. Both: rr pointer decides. On every grant the pointer moves to the non-granted requester.
- Read grant: A=rd_addr, CEN=0, GWEN=1, WEN=all 1.
- Write grant: A=wr_addr, D=wr_data, WEN=~wr_bmask. If wr_bmask≠0: CEN=0, GWEN=0. If wr_bmask=0: still granted, CEN=1 (no access).
- No grant: CEN=1, GWEN=1, WEN=all 1, A and D hold 0.
- rd_vld register: set next cycle after a read grant, else cleared. rd_data = sram_Q passthrough.
- Requester holds req/addr/data stable until it sees gnt. Deasserting req without a gnt is legal.

## Timing
- Whenever RST=1 (sampled), the same cycle's SRAM outputs are CEN=1, GWEN=1, WEN=all 1, A=0, D=0, rd_gnt=wr_gnt=0, init_busy=1. rd_vld=0 from the following edge.
- Init: 1024 cycles, from the first cycle with RST=0. init_busy falls at edge 1024. The first grant is possible in cycle 1024, counting from 0.
- Read latency: grant in cycle N, then rd_vld=1 and rd_data valid in N+1. Back-to-back reads give one result per cycle.
- Write then read of the same address in consecutive cycles returns the new data, because the SRAM orders accesses.
- RST during RUN: any read granted in the same cycle as RST=1 is not issued. If RST rises the cycle after a read grant, rd_vld is forced 0. INIT restarts at address 0.
- Counter width ADDR_WIDTH+1 or a terminal compare at 1023. There is no wrap into RUN other than through the terminal compare.

## Test plan
- Release RST, hold rd_req=wr_req=1 -> 1024 cycles of CEN=0/GWEN=0/WEN=0/D=0 at A=0..1023 in order, no gnt; init_busy falls after 1024 cycles; next cycle rd_gnt=1.
- Write 0x0123456789ABCDEF to addr 5 with mask all-ones, then read addr 5 -> rd_vld one cycle after rd_gnt, rd_data=0x0123456789ABCDEF.
- Then write 0xFFFFFFFFFFFFFFFF to addr 5 with mask 0x00000000FFFFFFFF, then read addr 5 -> 0x01234567FFFFFFFF.
- rd_req and wr_req held together for 4 cycles after init -> grants rd, wr, rd, wr; exactly one gnt per cycle; rd_vld follows each read grant.
- Read grant at cycle N, RST=1 at N+1 for one cycle -> rd_vld stays 0; sweep restarts at A=0; a read of addr 5 after the sweep returns 0.
- Write with wr_bmask=0 to addr 7 holding 0xAA -> wr_gnt=1, CEN stays 1, a later read of addr 7 returns 0xAA.

Source files
------------

// File: rtl/ct_spsram_1024x64_ctrl.sv
// Single-port IFU SRAM access controller: clears the array after reset, then
// round-robin arbitrates one read and one write requester onto the SRAM pins.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clear sweep, one zero write per cycle at address r_cnt
// ST_RUN  | normal operation, read/write requesters arbitrated
module ct_spsram_1024x64_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_bmask,
   output logic                  wr_gnt,
   output logic                  init_busy,
   output logic [ADDR_WIDTH-1:0] sram_A,
   output logic                  sram_CEN,
   output logic                  sram_GWEN,
   output logic [DATA_WIDTH-1:0] sram_WEN,
   output logic [DATA_WIDTH-1:0] sram_D,
   input  logic [DATA_WIDTH-1:0] sram_Q
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [ADDR_WIDTH-1:0] LP_LAST = '1;
   localparam logic                  RR_RD   = 1'b0;
   localparam logic                  RR_WR   = 1'b1;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic                    r_rr;
   logic                    r_rd_vld;

   logic                    w_run;
   logic                    w_init;
   logic                    w_rd_gnt;
   logic                    w_wr_gnt;
   logic [ADDR_WIDTH-1:0]   w_a;
   logic                    w_cen;
   logic                    w_gwen;
   logic [DATA_WIDTH-1:0]   w_wen;
   logic [DATA_WIDTH-1:0]   w_d;

   // RST masks everything combinationally so a grant in the reset cycle never reaches the pins.
   always_comb begin
      w_run    = !RST && (r_state == ST_RUN);
      w_init   = !RST && (r_state == ST_INIT);
      w_rd_gnt = w_run && rd_req && (!wr_req || (r_rr == RR_RD));
      w_wr_gnt = w_run && wr_req && (!rd_req || (r_rr == RR_WR));
      w_a      = '0;
      w_cen    = 1'b1;
      w_gwen   = 1'b1;
      w_wen    = '1;
      w_d      = '0;
      if (w_init) begin
         w_a    = r_cnt;
         w_cen  = 1'b0;
         w_gwen = 1'b0;
         w_wen  = '0;
      end else if (w_rd_gnt) begin
         w_a   = rd_addr;
         w_cen = 1'b0;
      end else if (w_wr_gnt) begin
         w_a   = wr_addr;
         w_d   = wr_data;
         w_wen = ~wr_bmask;
         if (wr_bmask != '0) begin
            w_cen  = 1'b0;
            w_gwen = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= ST_INIT;
         r_cnt    <= '0;
         r_rr     <= RR_RD;
         r_rd_vld <= 1'b0;
      end else begin
         r_rd_vld <= w_rd_gnt;
         case (r_state)
            ST_INIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LP_LAST)
                  r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_rd_gnt)
                  r_rr <= RR_WR;
               else if (w_wr_gnt)
                  r_rr <= RR_RD;
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign rd_gnt    = w_rd_gnt;
   assign wr_gnt    = w_wr_gnt;
   assign rd_vld    = r_rd_vld && !RST;
   assign rd_data   = sram_Q;
   assign init_busy = RST || (r_state == ST_INIT);
   assign sram_A    = w_a;
   assign sram_CEN  = w_cen;
   assign sram_GWEN = w_gwen;
   assign sram_WEN  = w_wen;
   assign sram_D    = w_d;

endmodule

// File: tb/tb_ct_spsram_1024x64_ctrl.sv
// Bench for ct_spsram_1024x64_ctrl: behavioural SRAM, arbitration vector table,
// read-data scoreboard and hand-written reset / mask sequences.
module tb_ct_spsram_1024x64_ctrl;

   localparam logic [63:0] ONES = {64{1'b1}};

   logic        clk;
   logic        RST;
   logic        rd_req, wr_req;
   logic [9:0]  rd_addr, wr_addr;
   logic [63:0] wr_data, wr_bmask;
   logic        rd_gnt, rd_vld, wr_gnt, init_busy;
   logic [63:0] rd_data;
   logic [9:0]  sram_A;
   logic        sram_CEN, sram_GWEN;
   logic [63:0] sram_WEN, sram_D, sram_Q;

   int total = 0;
   int bad   = 0;

   logic [63:0] mem [1024];
   bit          filled = 1'b0;
   logic [63:0] exp_mem [1024];
   logic [63:0] sb_q [$];

   typedef struct {
      logic        rq, wq;
      logic [9:0]  ra, wa;
      logic [63:0] wd, wm;
      logic        erg, ewg;
   } vec_t;
   vec_t tbl [10];

   ct_spsram_1024x64_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut (
      .CLK(clk), .RST(RST),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bmask(wr_bmask), .wr_gnt(wr_gnt),
      .init_busy(init_busy),
      .sram_A(sram_A), .sram_CEN(sram_CEN), .sram_GWEN(sram_GWEN),
      .sram_WEN(sram_WEN), .sram_D(sram_D), .sram_Q(sram_Q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural SRAM, starts full of garbage so the clear sweep is visible in read data.
   always @(posedge clk) begin
      if (!filled) begin
         for (int i = 0; i < 1024; i++) mem[i] <= {$urandom, $urandom};
         filled <= 1'b1;
      end else if (!sram_CEN) begin
         if (!sram_GWEN)
            mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
         else
            sram_Q <= mem[sram_A];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish before 2ms");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic monitor();
      logic pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (RST) begin
               chk("rd_vld_rst", {63'd0, rd_vld}, 64'd0);
               void'(sb_q.pop_front());
            end else begin
               chk("rd_vld", {63'd0, rd_vld}, 64'd1);
               chk("rd_data", rd_data, sb_q.pop_front());
            end
         end else begin
            chk("rd_vld_idle", {63'd0, rd_vld}, 64'd0);
         end
         chk("one_gnt", {63'd0, rd_gnt & wr_gnt}, 64'd0);
         if (RST)
            for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
         pend = rd_gnt;
         if (rd_gnt) sb_q.push_back(exp_mem[rd_addr]);
         if (wr_gnt) exp_mem[wr_addr] = (exp_mem[wr_addr] & ~wr_bmask) | (wr_data & wr_bmask);
      end
   endtask

   task automatic chk_rst_pins();
      chk("rst_cen",  {63'd0, sram_CEN},  64'd1);
      chk("rst_gwen", {63'd0, sram_GWEN}, 64'd1);
      chk("rst_wen",  sram_WEN, ONES);
      chk("rst_a",    {54'd0, sram_A}, 64'd0);
      chk("rst_d",    sram_D, 64'd0);
      chk("rst_gnt",  {62'd0, rd_gnt, wr_gnt}, 64'd0);
      chk("rst_busy", {63'd0, init_busy}, 64'd1);
   endtask

   // Called at cycle 0 of a sweep; returns just after the edge that starts cycle 1024.
   task automatic sweep();
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         chk("init_a",   {54'd0, sram_A}, 64'(i));
         chk("init_ctl", {59'd0, sram_CEN, sram_GWEN, rd_gnt, wr_gnt, init_busy}, 64'd1);
         chk("init_wen", sram_WEN, 64'd0);
         chk("init_d",   sram_D, 64'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_read(input logic [9:0] a);
      bit got = 1'b0;
      rd_req = 1'b1; rd_addr = a; wr_req = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         if (rd_gnt) begin
            got = 1'b1;
            chk("rd_a",   {54'd0, sram_A}, {54'd0, a});
            chk("rd_ctl", {62'd0, sram_CEN, sram_GWEN}, 64'd1);
            chk("rd_wen", sram_WEN, ONES);
         end
         @(posedge clk); #1;
      end
      if (!got) chk("rd_timeout", 64'd0, 64'd1);
      rd_req = 1'b0;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [63:0] d, input logic [63:0] m);
      bit got = 1'b0;
      wr_req = 1'b1; wr_addr = a; wr_data = d; wr_bmask = m; rd_req = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         if (wr_gnt) begin
            got = 1'b1;
            chk("wr_a",   {54'd0, sram_A}, {54'd0, a});
            chk("wr_d",   sram_D, d);
            chk("wr_wen", sram_WEN, ~m);
            chk("wr_ctl", {62'd0, sram_CEN, sram_GWEN}, (m == 64'd0) ? 64'd3 : 64'd0);
         end
         @(posedge clk); #1;
      end
      if (!got) chk("wr_timeout", 64'd0, 64'd1);
      wr_req = 1'b0;
   endtask

   initial begin
      logic [63:0] e_a, e_wen, e_d;
      logic        e_cen, e_gwen;

      tbl[0] = '{1'b1, 1'b1, 10'd5,    10'd100, 64'h1111_2222_3333_4444, ONES, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 10'd100,  10'd100, 64'h1111_2222_3333_4444, ONES, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 10'd100,  10'd101, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 10'd101,  10'd101, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_FFFF, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 10'd0,    10'd0,   64'h0, 64'h0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 10'd0,    10'd102, 64'h5A5A_5A5A_5A5A_5A5A, 64'hFF00_FF00_FF00_FF00, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 10'd101,  10'd103, 64'h0F0F_0F0F_0F0F_0F0F, ONES, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 10'd102,  10'd0,   64'h0, 64'h0, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 10'd1023, 10'd0,   64'h0, 64'h0, 1'b1, 1'b0};
      tbl[9] = '{1'b1, 1'b1, 10'd0,    10'd103, 64'h0F0F_0F0F_0F0F_0F0F, ONES, 1'b0, 1'b1};

      RST = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
      rd_addr = 10'd3; wr_addr = 10'd4; wr_data = 64'hFFFF; wr_bmask = ONES;
      fork monitor(); join_none
      repeat (3) begin
         @(negedge clk); chk_rst_pins();
         @(posedge clk); #1;
      end
      RST = 1'b0;
      sweep();

      // Arbitration table, starting in the first RUN cycle with both requests still up.
      for (int i = 0; i < 10; i++) begin
         rd_req = tbl[i].rq; wr_req = tbl[i].wq; rd_addr = tbl[i].ra;
         wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_bmask = tbl[i].wm;
         e_a    = tbl[i].erg ? {54'd0, tbl[i].ra} : tbl[i].ewg ? {54'd0, tbl[i].wa} : 64'd0;
         e_cen  = !(tbl[i].erg || (tbl[i].ewg && tbl[i].wm != 64'd0));
         e_gwen = !(tbl[i].ewg && tbl[i].wm != 64'd0);
         e_wen  = tbl[i].ewg ? ~tbl[i].wm : ONES;
         e_d    = tbl[i].ewg ? tbl[i].wd : 64'd0;
         @(negedge clk);
         chk($sformatf("v%0d_gnt", i), {62'd0, rd_gnt, wr_gnt}, {62'd0, tbl[i].erg, tbl[i].ewg});
         chk($sformatf("v%0d_busy", i), {63'd0, init_busy}, 64'd0);
         chk($sformatf("v%0d_a", i), {54'd0, sram_A}, e_a);
         chk($sformatf("v%0d_ctl", i), {62'd0, sram_CEN, sram_GWEN}, {62'd0, e_cen, e_gwen});
         chk($sformatf("v%0d_wen", i), sram_WEN, e_wen);
         chk($sformatf("v%0d_d", i), sram_D, e_d);
         @(posedge clk); #1;
      end
      rd_req = 1'b0; wr_req = 1'b0;
      @(posedge clk); #1;

      do_write(10'd5, 64'h0123_4567_89AB_CDEF, ONES);
      do_read(10'd5);
      @(negedge clk); chk("addr5_full", rd_data, 64'h0123_4567_89AB_CDEF);
      @(posedge clk); #1;
      do_write(10'd5, ONES, 64'h0000_0000_FFFF_FFFF);
      do_read(10'd5);
      @(negedge clk); chk("addr5_mask", rd_data, 64'h0123_4567_FFFF_FFFF);
      @(posedge clk); #1;

      do_write(10'd7, 64'hAA, ONES);
      do_write(10'd7, 64'h55, 64'd0);
      do_read(10'd7);
      @(negedge clk); chk("addr7_nomask", rd_data, 64'hAA);
      @(posedge clk); #1;

      // Read granted, then RST in the following cycle with a new read pending.
      do_read(10'd5);
      RST = 1'b1; rd_req = 1'b1; rd_addr = 10'd9;
      @(negedge clk);
      chk("rst_rd_vld", {63'd0, rd_vld}, 64'd0);
      chk_rst_pins();
      @(posedge clk); #1;
      RST = 1'b0;
      sweep();
      rd_req = 1'b0;
      do_read(10'd5);
      @(negedge clk); chk("addr5_cleared", rd_data, 64'd0);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
